// File: rtl/soc_ecp5.sv
// rtl/soc_ecp5.sv - ECP5 bring-up top: reset sync, PHY reset, heartbeat, PWM, optional UART banner (UART_BANNER_EN)
module soc_ecp5 #(
    parameter int LED_DIV        = 12500000,
    parameter int PHY_RST_CYCLES = 250000,
    parameter int BAUD_DIV       = 217,
    parameter int GAP_CYCLES     = 2500000,
    parameter int PWM_DUTY       = 128
) (
    input  logic osc_clk25,
    input  logic button,
    output logic led,
    output logic phy_rst_,
    output logic J1_1,
    output logic J1_2,
    output logic J1_3,
    output logic J1_5,
    output logic J1_6,
    output logic J1_7,
    output logic J1_8,
    output logic J1_9,
    output logic J1_10,
    output logic J1_11,
    output logic J1_12,
    output logic J1_13,
    output logic J1_14,
    output logic J1_15
);

    localparam int LW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
    localparam int PW = (PHY_RST_CYCLES > 1) ? $clog2(PHY_RST_CYCLES) : 1;
    localparam logic [LW-1:0] LED_LAST = LW'(LED_DIV - 1);
    localparam logic [PW-1:0] PHY_LAST = PW'(PHY_RST_CYCLES - 1);
    localparam logic [7:0]    PWM_CMP  = PWM_DUTY[7:0];

    logic sync1_q, sync1_d;
    logic rst_q, rst_d;
    logic [LW-1:0] led_cnt_q, led_cnt_d;
    logic led_q, led_d;
    logic beat_q, beat_d;
    logic [PW-1:0] phy_cnt_q, phy_cnt_d;
    logic phy_q, phy_d;
    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic pwm_q, pwm_d;

    // Button synchronizer: rst follows the inverted second stage
    always_comb begin
        sync1_d = button;
        rst_d   = ~sync1_q;
    end

    // Synchronizer flops carry no reset; they are the reset source
    always_ff @(posedge osc_clk25) begin
        sync1_q <= sync1_d;
        rst_q   <= rst_d;
    end

    // Heartbeat divider, led toggle and one-cycle beat pulse
    always_comb begin
        led_cnt_d = led_cnt_q + 1'b1;
        led_d     = led_q;
        beat_d    = 1'b0;
        if (led_cnt_q == LED_LAST) begin
            led_cnt_d = '0;
            led_d     = ~led_q;
            beat_d    = 1'b1;
        end
    end

    // PHY reset counter saturates once the PHY is released
    always_comb begin
        phy_cnt_d = phy_cnt_q;
        phy_d     = phy_q;
        if (!phy_q) begin
            if (phy_cnt_q == PHY_LAST) begin
                phy_d = 1'b1;
            end else begin
                phy_cnt_d = phy_cnt_q + 1'b1;
            end
        end
    end

    // Compare against the next counter value so J1_3 lines up with the count
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_d     = (pwm_cnt_d < PWM_CMP);
    end

    // Heartbeat, PHY reset and PWM state
    always_ff @(posedge osc_clk25) begin
        if (rst_q) begin
            led_cnt_q <= '0;
            led_q     <= 1'b0;
            beat_q    <= 1'b0;
            phy_cnt_q <= '0;
            phy_q     <= 1'b0;
            pwm_cnt_q <= 8'd0;
            pwm_q     <= 1'b0;
        end else begin
            led_cnt_q <= led_cnt_d;
            led_q     <= led_d;
            beat_q    <= beat_d;
            phy_cnt_q <= phy_cnt_d;
            phy_q     <= phy_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_q     <= pwm_d;
        end
    end

    assign led      = led_q;
    assign phy_rst_ = phy_q;
    assign J1_3     = pwm_q;
    assign J1_13    = beat_q;
    assign J1_14    = phy_q;
    assign J1_15    = rst_q;

`ifdef UART_BANNER_EN
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    localparam logic [2:0] ST_WAIT_PHY = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_STOP     = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    function automatic logic [7:0] banner_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h4F;
            2'd1:    return 8'h4B;
            2'd2:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic [7:0]    data_q, data_d;

    // Banner FSM; tx_d is the level of the bit the next state drives
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        data_d  = data_q;
        case (state_q)
            ST_WAIT_PHY: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (phy_q) begin
                    state_d = ST_START;
                    baud_d  = '0;
                    byte_d  = 2'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    data_d  = banner_byte(2'd0);
                end
            end
            ST_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                    tx_d    = data_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (byte_q == 2'd3) begin
                        state_d = ST_GAP;
                        busy_d  = 1'b0;
                        gap_d   = '0;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                        data_d  = banner_byte(byte_q + 2'd1);
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_START;
                    byte_d  = 2'd0;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    data_d  = banner_byte(2'd0);
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_PHY;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Banner state; rst aborts any byte in flight
    always_ff @(posedge osc_clk25) begin
        if (rst_q) begin
            state_q <= ST_WAIT_PHY;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            gap_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
        end
    end

    assign J1_1 = tx_q;
    assign J1_2 = busy_q;
    assign {J1_12, J1_11, J1_10, J1_9, J1_8, J1_7, J1_6, J1_5} = data_q;
`else
    assign J1_1 = 1'b1;
    assign J1_2 = 1'b0;
    assign {J1_12, J1_11, J1_10, J1_9, J1_8, J1_7, J1_6, J1_5} = 8'd0;
`endif

endmodule

// File: tb/tb_soc_ecp5.sv
// tb/tb_soc_ecp5.sv - self-checking bench for soc_ecp5 (banner checks follow UART_BANNER_EN)
module tb_soc_ecp5;

    localparam int LED_DIV   = 8;
    localparam int PHY_CYC   = 16;
    localparam int BAUD      = 4;
    localparam int GAP       = 20;
    localparam int DUTY      = 64;
    localparam int BYTE_CYC  = 10 * BAUD;
    localparam int FRAME_CYC = 4 * BYTE_CYC + GAP;
    localparam int TX_START  = PHY_CYC + 1;

    logic clk = 1'b0;
    logic button = 1'b0;
    logic led, phy_rst_, J1_1, J1_2, J1_3;
    logic J1_5, J1_6, J1_7, J1_8, J1_9, J1_10, J1_11, J1_12;
    logic J1_13, J1_14, J1_15;
    logic [7:0] dbg;

    int total = 0;
    int bad = 0;
    int k = 0;

    assign dbg = {J1_12, J1_11, J1_10, J1_9, J1_8, J1_7, J1_6, J1_5};

    always #1 clk = ~clk;

    soc_ecp5 #(
        .LED_DIV(LED_DIV), .PHY_RST_CYCLES(PHY_CYC), .BAUD_DIV(BAUD),
        .GAP_CYCLES(GAP), .PWM_DUTY(DUTY)
    ) dut (
        .osc_clk25(clk), .button(button), .led(led), .phy_rst_(phy_rst_),
        .J1_1(J1_1), .J1_2(J1_2), .J1_3(J1_3),
        .J1_5(J1_5), .J1_6(J1_6), .J1_7(J1_7), .J1_8(J1_8),
        .J1_9(J1_9), .J1_10(J1_10), .J1_11(J1_11), .J1_12(J1_12),
        .J1_13(J1_13), .J1_14(J1_14), .J1_15(J1_15)
    );

    function automatic logic [7:0] banner(input int i);
        case (i)
            0:       return 8'h4F;
            1:       return 8'h4B;
            2:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // Reference model: outputs at cycle kk after the edge rst deasserted
    function automatic logic exp_led(input int kk);
        return ((kk / LED_DIV) % 2) == 1;
    endfunction

    function automatic logic exp_beat(input int kk);
        return (kk >= LED_DIV) && ((kk % LED_DIV) == 0);
    endfunction

    function automatic logic exp_phy(input int kk);
        return kk >= PHY_CYC;
    endfunction

    function automatic logic exp_pwm(input int kk);
        return (kk >= 1) && ((kk % 256) < DUTY);
    endfunction

    function automatic logic exp_tx(input int kk);
`ifdef UART_BANNER_EN
        int u, b;
        logic [7:0] v;
        if (kk < TX_START) return 1'b1;
        u = (kk - TX_START) % FRAME_CYC;
        if (u >= 4 * BYTE_CYC) return 1'b1;
        b = (u % BYTE_CYC) / BAUD;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        v = banner(u / BYTE_CYC);
        return v[b-1];
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic exp_busy(input int kk);
`ifdef UART_BANNER_EN
        if (kk < TX_START) return 1'b0;
        return ((kk - TX_START) % FRAME_CYC) < 4 * BYTE_CYC;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] exp_dbg(input int kk);
`ifdef UART_BANNER_EN
        int u;
        if (kk < TX_START) return 8'h00;
        u = (kk - TX_START) % FRAME_CYC;
        if (u >= 4 * BYTE_CYC) return 8'h0A;
        return banner(u / BYTE_CYC);
`else
        return 8'h00;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        k = k + 1;
        @(negedge clk);
    endtask

    task automatic press_hold(input int n);
        button = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic release_rst();
        button = 1'b1;
        repeat (2) @(negedge clk);
        k = 0;
    endtask

    task automatic test_reset();
        int n;
        n = $urandom_range(9, 5);
        @(negedge clk);
        press_hold(n);
        total++; if (J1_15 !== 1'b1) begin bad++; $display("FAIL rst_j15 got=%b want=1", J1_15); end
        total++; if (led !== 1'b0) begin bad++; $display("FAIL rst_led got=%b want=0", led); end
        total++; if (phy_rst_ !== 1'b0) begin bad++; $display("FAIL rst_phy got=%b want=0", phy_rst_); end
        total++; if (J1_14 !== 1'b0) begin bad++; $display("FAIL rst_j14 got=%b want=0", J1_14); end
        total++; if (J1_1 !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b want=1", J1_1); end
        total++; if (J1_2 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", J1_2); end
        total++; if (J1_3 !== 1'b0) begin bad++; $display("FAIL rst_pwm got=%b want=0", J1_3); end
        total++; if (J1_13 !== 1'b0) begin bad++; $display("FAIL rst_beat got=%b want=0", J1_13); end
        total++; if (dbg !== 8'h00) begin bad++; $display("FAIL rst_dbg got=%h want=00", dbg); end
        button = 1'b1;
        @(negedge clk);
        total++; if (J1_15 !== 1'b1) begin bad++; $display("FAIL rel_edge1 got=%b want=1", J1_15); end
        @(negedge clk);
        total++; if (J1_15 !== 1'b0) begin bad++; $display("FAIL rel_edge2 got=%b want=0", J1_15); end
        k = 0;
    endtask

    task automatic test_heartbeat();
        press_hold($urandom_range(8, 4));
        release_rst();
        for (int i = 0; i < 5 * LED_DIV; i++) begin
            step();
            total++; if (led !== exp_led(k)) begin bad++; $display("FAIL led k=%0d got=%b want=%b", k, led, exp_led(k)); end
            total++; if (J1_13 !== exp_beat(k)) begin bad++; $display("FAIL beat k=%0d got=%b want=%b", k, J1_13, exp_beat(k)); end
        end
    endtask

    task automatic test_phy();
        press_hold($urandom_range(8, 4));
        release_rst();
        total++; if (phy_rst_ !== 1'b0) begin bad++; $display("FAIL phy_k0 got=%b want=0", phy_rst_); end
        for (int i = 0; i < 3 * PHY_CYC; i++) begin
            step();
            total++; if (phy_rst_ !== exp_phy(k)) begin bad++; $display("FAIL phy k=%0d got=%b want=%b", k, phy_rst_, exp_phy(k)); end
            total++; if (J1_14 !== exp_phy(k)) begin bad++; $display("FAIL j14 k=%0d got=%b want=%b", k, J1_14, exp_phy(k)); end
            total++; if (J1_15 !== 1'b0) begin bad++; $display("FAIL j15_run k=%0d got=%b want=0", k, J1_15); end
        end
    endtask

    task automatic test_uart();
        press_hold($urandom_range(8, 4));
        release_rst();
        for (int i = 0; i < 2 * FRAME_CYC + 60; i++) begin
            step();
            total++; if (J1_1 !== exp_tx(k)) begin bad++; $display("FAIL tx k=%0d got=%b want=%b", k, J1_1, exp_tx(k)); end
            total++; if (J1_2 !== exp_busy(k)) begin bad++; $display("FAIL busy k=%0d got=%b want=%b", k, J1_2, exp_busy(k)); end
            total++; if (dbg !== exp_dbg(k)) begin bad++; $display("FAIL dbg k=%0d got=%h want=%h", k, dbg, exp_dbg(k)); end
        end
    endtask

    task automatic test_pwm();
        int highs;
        highs = 0;
        press_hold($urandom_range(8, 4));
        release_rst();
        for (int i = 0; i < 600; i++) begin
            step();
            total++; if (J1_3 !== exp_pwm(k)) begin bad++; $display("FAIL pwm k=%0d got=%b want=%b", k, J1_3, exp_pwm(k)); end
            if (k >= 256 && k < 512 && J1_3 === 1'b1) highs++;
        end
        total++; if (highs != DUTY) begin bad++; $display("FAIL pwm_highs got=%0d want=%0d", highs, DUTY); end
    endtask

    task automatic test_abort(input int kp);
        press_hold($urandom_range(8, 4));
        release_rst();
        while (k < kp) begin
            step();
            total++; if (J1_1 !== exp_tx(k)) begin bad++; $display("FAIL ab_tx k=%0d got=%b want=%b", k, J1_1, exp_tx(k)); end
            total++; if (phy_rst_ !== exp_phy(k)) begin bad++; $display("FAIL ab_phy k=%0d got=%b want=%b", k, phy_rst_, exp_phy(k)); end
        end
        button = 1'b0;
        step();
        total++; if (J1_15 !== 1'b0) begin bad++; $display("FAIL ab_j15_e1 got=%b want=0", J1_15); end
        step();
        total++; if (J1_15 !== 1'b1) begin bad++; $display("FAIL ab_j15_e2 got=%b want=1", J1_15); end
        step();
        total++; if (J1_1 !== 1'b1) begin bad++; $display("FAIL ab_tx_idle got=%b want=1", J1_1); end
        total++; if (J1_2 !== 1'b0) begin bad++; $display("FAIL ab_busy got=%b want=0", J1_2); end
        total++; if (phy_rst_ !== 1'b0) begin bad++; $display("FAIL ab_phy_low got=%b want=0", phy_rst_); end
        total++; if (J1_14 !== 1'b0) begin bad++; $display("FAIL ab_j14 got=%b want=0", J1_14); end
        total++; if (led !== 1'b0) begin bad++; $display("FAIL ab_led got=%b want=0", led); end
        press_hold($urandom_range(4, 1));
        release_rst();
        for (int i = 0; i < TX_START + 2 * BYTE_CYC; i++) begin
            step();
            total++; if (J1_1 !== exp_tx(k)) begin bad++; $display("FAIL re_tx k=%0d got=%b want=%b", k, J1_1, exp_tx(k)); end
            total++; if (J1_2 !== exp_busy(k)) begin bad++; $display("FAIL re_busy k=%0d got=%b want=%b", k, J1_2, exp_busy(k)); end
            total++; if (dbg !== exp_dbg(k)) begin bad++; $display("FAIL re_dbg k=%0d got=%h want=%h", k, dbg, exp_dbg(k)); end
            total++; if (phy_rst_ !== exp_phy(k)) begin bad++; $display("FAIL re_phy k=%0d got=%b want=%b", k, phy_rst_, exp_phy(k)); end
        end
    endtask

    initial begin
        test_reset();
        test_heartbeat();
        test_phy();
        test_uart();
        test_pwm();
        // second data bit of 0x4B, then a random point
        test_abort(TX_START + BYTE_CYC + 2 * BAUD);
        test_abort($urandom_range(300, 20));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
